// File: rtl/vending_pkg.sv
// Shared coin codes, FSM state type and coin-value decode for the vending change controller.
// Optional refund support elsewhere in the slice is selected by VEND_CANCEL_EN.
package vending_pkg;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;
    localparam logic [1:0] COIN_25   = 2'b11;

    typedef enum logic {
        COLLECT = 1'b0,
        CHANGE  = 1'b1
    } state_e;

    // Credit value of a coin code in 5-unit steps.
    function automatic logic [2:0] coin_steps(input logic [1:0] coin);
        case (coin)
            COIN_5:  coin_steps = 3'd1;
            COIN_10: coin_steps = 3'd2;
            COIN_25: coin_steps = 3'd5;
            default: coin_steps = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/vending_change_ctrl_if.sv
// Coin-acceptor / actuator bus of the vending change controller.
// The cancel signal exists only when VEND_CANCEL_EN is defined.
interface vending_change_ctrl_if #(
    parameter int CREDIT_W = 8
);
    logic [1:0]          coin;
`ifdef VEND_CANCEL_EN
    logic                cancel;
`endif
    logic                chg_ready;
    logic                dispense;
    logic                chg5;
    logic                coin_reject;
    logic [CREDIT_W-1:0] credit;

`ifdef VEND_CANCEL_EN
    modport master (output coin, cancel, chg_ready,
                    input  dispense, chg5, coin_reject, credit);
    modport slave  (input  coin, cancel, chg_ready,
                    output dispense, chg5, coin_reject, credit);
`else
    modport master (output coin, chg_ready,
                    input  dispense, chg5, coin_reject, credit);
    modport slave  (input  coin, chg_ready,
                    output dispense, chg5, coin_reject, credit);
`endif

endinterface

// File: rtl/vend_change_ctr.sv
// Loadable change-token down-counter; offers one 5-unit token per cycle over chg5/chg_ready.
module vend_change_ctr #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         chg_ready,
    output logic         chg5,
    output logic         done
);

    logic [W-1:0] count_q, count_d;
    logic         chg5_q, chg5_d;

    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latch can be inferred.
        count_d = count_q;
        chg5_d  = chg5_q;
        if (load) begin
            count_d = load_val;
            chg5_d  = (load_val != '0);
        end else if (chg5_q && chg_ready) begin
            count_d = count_q - W'(1);
            chg5_d  = (count_q != W'(1));
        end
    end

    // NOTE: state flops use non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            chg5_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            chg5_q  <= chg5_d;
        end
    end

    assign chg5 = chg5_q;
    assign done = chg5_q && chg_ready && (count_q == W'(1));

endmodule

// File: rtl/vending_change_ctrl.sv
// Vending controller: accumulates coin credit up to PRICE_UNITS, pulses dispense, streams change.
// Define VEND_CANCEL_EN to add the refund (cancel) button.
module vending_change_ctrl
    import vending_pkg::*;
#(
    parameter int PRICE_UNITS = 4,
    parameter int CREDIT_W    = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    vending_change_ctrl_if.slave  bus
);

    localparam logic [CREDIT_W:0] PRICE = (CREDIT_W+1)'(PRICE_UNITS);

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                dispense_q, dispense_d;
    logic [CREDIT_W:0]   sum;
    logic                load;
    logic [CREDIT_W-1:0] load_val;
    logic                done;
    logic                cancel_take;

`ifdef VEND_CANCEL_EN
    assign cancel_take = (state_q == COLLECT) && bus.cancel && (credit_q != '0);
`else
    assign cancel_take = 1'b0;
`endif

    // One extra bit keeps the sum exact when credit sits just below a large price.
    assign sum = {1'b0, credit_q} + (CREDIT_W+1)'(coin_steps(bus.coin));

    always_comb begin
        state_d    = state_q;
        credit_d   = credit_q;
        dispense_d = 1'b0;
        load       = 1'b0;
        load_val   = '0;
        case (state_q)
            COLLECT: begin
                if (cancel_take) begin
                    load     = 1'b1;
                    load_val = credit_q;
                    credit_d = '0;
                    state_d  = CHANGE;
                end else if (bus.coin != COIN_NONE) begin
                    if (sum >= PRICE) begin
                        dispense_d = 1'b1;
                        credit_d   = '0;
                        load       = 1'b1;
                        load_val   = CREDIT_W'(sum - PRICE);
                        if (sum != PRICE) state_d = CHANGE;
                    end else begin
                        credit_d = sum[CREDIT_W-1:0];
                    end
                end
            end
            CHANGE: begin
                if (done) state_d = COLLECT;
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= COLLECT;
            credit_q   <= '0;
            dispense_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            dispense_q <= dispense_d;
        end
    end

    vend_change_ctr #(.W(CREDIT_W)) u_change_ctr (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (load),
        .load_val  (load_val),
        .chg_ready (bus.chg_ready),
        .chg5      (bus.chg5),
        .done      (done)
    );

    assign bus.coin_reject = (bus.coin != COIN_NONE) && ((state_q == CHANGE) || cancel_take);
    assign bus.dispense    = dispense_q;
    assign bus.credit      = credit_q;

endmodule

// File: tb/tb_vending_change_ctrl.sv
// Self-checking bench for vending_change_ctrl: directed scenarios plus random coins against a
// credit/pending-change reference model; cancel stimulus is effective only with VEND_CANCEL_EN.
module tb_vending_change_ctrl;

    localparam int PRICE = 4;
    localparam int CW    = 8;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    vending_change_ctrl_if #(.CREDIT_W(CW)) bus ();

    vending_change_ctrl #(.PRICE_UNITS(PRICE), .CREDIT_W(CW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int m_credit;
    int m_pending;
    bit m_dispense;
    int tokens;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int coin_value(input logic [1:0] c);
        case (c)
            2'b01:   return 1;
            2'b10:   return 2;
            2'b11:   return 5;
            default: return 0;
        endcase
    endfunction

    // One clock cycle, entered and left at the falling edge.
    task automatic cycle(input logic [1:0] c, input bit cxl, input bit rdy);
        bit eff_cxl;
        bit exp_rej;
        int sum;
        bus.coin      = c;
        bus.chg_ready = rdy;
`ifdef VEND_CANCEL_EN
        bus.cancel = cxl;
        eff_cxl    = cxl;
`else
        eff_cxl    = cxl && 1'b0;
`endif
        #1;
        exp_rej = (c != 2'b00) && (m_pending > 0 || (eff_cxl && m_credit > 0));
        check("coin_reject", {31'd0, bus.coin_reject}, {31'd0, exp_rej});
        m_dispense = 1'b0;
        if (m_pending > 0) begin
            if (rdy) begin
                m_pending--;
                tokens++;
            end
        end else if (eff_cxl && m_credit > 0) begin
            m_pending = m_credit;
            m_credit  = 0;
        end else if (c != 2'b00) begin
            sum = m_credit + coin_value(c);
            if (sum >= PRICE) begin
                m_dispense = 1'b1;
                m_credit   = 0;
                m_pending  = sum - PRICE;
            end else begin
                m_credit = sum;
            end
        end
        @(posedge clk);
        #1;
        check("dispense", {31'd0, bus.dispense}, {31'd0, m_dispense});
        check("chg5", {31'd0, bus.chg5}, (m_pending > 0) ? 32'd1 : 32'd0);
        check("credit", {24'd0, bus.credit}, m_credit);
        @(negedge clk);
    endtask

    // Asynchronous reset pulse during the low clock phase; outputs must clear at once.
    task automatic pulse_reset();
        bus.coin      = 2'b00;
        bus.chg_ready = 1'b0;
`ifdef VEND_CANCEL_EN
        bus.cancel = 1'b0;
`endif
        reset_n = 1'b0;
        #1;
        check("rst_chg5", {31'd0, bus.chg5}, 32'd0);
        check("rst_dispense", {31'd0, bus.dispense}, 32'd0);
        check("rst_credit", {24'd0, bus.credit}, 32'd0);
        m_credit   = 0;
        m_pending  = 0;
        m_dispense = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        bus.coin      = 2'b00;
        bus.chg_ready = 1'b0;
`ifdef VEND_CANCEL_EN
        bus.cancel = 1'b0;
`endif
        m_credit  = 0;
        m_pending = 0;
        tokens    = 0;
        @(negedge clk);
        pulse_reset();

        // Four 5-unit coins reach the price exactly; no change owed.
        repeat (4) cycle(2'b01, 1'b0, 1'b1);
        cycle(2'b00, 1'b0, 1'b1);

        // 10 then 25: sum 7, three tokens with ready held high.
        cycle(2'b10, 1'b0, 1'b1);
        cycle(2'b11, 1'b0, 1'b1);
        repeat (4) cycle(2'b00, 1'b0, 1'b1);

        // Change of 3 with ready toggled 1,0,0,1,1.
        cycle(2'b10, 1'b0, 1'b0);
        cycle(2'b11, 1'b0, 1'b0);
        tokens = 0;
        cycle(2'b00, 1'b0, 1'b1);
        cycle(2'b00, 1'b0, 1'b0);
        cycle(2'b00, 1'b0, 1'b0);
        cycle(2'b00, 1'b0, 1'b1);
        cycle(2'b00, 1'b0, 1'b1);
        check("stall_tokens", tokens, 32'd3);
        check("stall_chg5_end", {31'd0, bus.chg5}, 32'd0);

        // Coins during CHANGE, including its last cycle, are rejected; next coin credits.
        cycle(2'b11, 1'b0, 1'b0);
        cycle(2'b01, 1'b0, 1'b0);
        cycle(2'b01, 1'b0, 1'b1);
        cycle(2'b01, 1'b0, 1'b1);
        check("after_change_credit", {24'd0, bus.credit}, 32'd1);
        pulse_reset();

        // Cancel with simultaneous coin (refund of 3 when the feature is built in).
        cycle(2'b01, 1'b0, 1'b1);
        cycle(2'b10, 1'b0, 1'b1);
        cycle(2'b10, 1'b1, 1'b1);
        repeat (4) cycle(2'b00, 1'b0, 1'b1);
        cycle(2'b01, 1'b1, 1'b1);
        pulse_reset();

        // Reset mid-CHANGE with two tokens still pending.
        cycle(2'b10, 1'b0, 1'b1);
        cycle(2'b11, 1'b0, 1'b1);
        cycle(2'b00, 1'b0, 1'b1);
        check("pending_before_reset", {31'd0, bus.chg5}, 32'd1);
        pulse_reset();
        cycle(2'b01, 1'b0, 1'b1);
        check("credit_after_reset", {24'd0, bus.credit}, 32'd1);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                pulse_reset();
            end else begin
                cycle(2'($urandom_range(0, 3)),
                      ($urandom_range(0, 7) == 0),
                      ($urandom_range(0, 3) != 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vending_change_ctrl.md
# vending_change_ctrl

Parametrised vending controller: accumulates coin credit in 5-unit steps up to a configurable price, pulses `dispense` on reaching it, and returns any excess as a stream of 5-unit change tokens over a ready/valid handshake to the coin-return mechanism. It generalises the fixed 20-unit Mealy vending FSM to arbitrary price, adds a 25-unit coin and multi-token change, and optionally supports a cancel/refund button. It sits between the coin acceptor (one coin code per cycle) and the product/change actuators.

## Interface
- `PRICE_UNITS`, default 4: price in 5-unit steps; default 20. Legal range 1..255.
- `CREDIT_W`, default 8: width of the `credit` and change counters; must hold `PRICE_UNITS+4`.
- `clk` in, 1 bit: single clock, rising edge.
- `reset_n` in, 1 bit: asynchronous, active-low reset.
- `coin` in, 2 bits: 00 none, 01 5 units (1 step), 10 10 units (2), 11 25 units (5). Sampled every cycle.
- `cancel` in, 1 bit: refund request; level-sampled, present only with `VEND_CANCEL_EN`.
- `chg_ready` in, 1 bit: coin-return accepts one 5-unit token this cycle.
- `dispense` out, 1 bit: registered one-cycle vend pulse.
- `chg5` out, 1 bit: registered change-token valid.
- `coin_reject` out, 1 bit: combinational; the coin presented this cycle is not credited and is routed back.
- `credit` out, CREDIT_W: current accumulated credit in steps, registered.

## Operation
- States: COLLECT, CHANGE. Reset state is COLLECT; `credit`=0, change count=0, `dispense`=0, `chg5`=0.
- COLLECT, `coin`≠00, no cancel: let sum = `credit` + coin value.
  - sum < `PRICE_UNITS`: `credit` ← sum.
  - sum ≥ `PRICE_UNITS`: `dispense` ← 1 for one cycle, `credit` ← 0, change ← sum − `PRICE_UNITS`. If change > 0, go to CHANGE; otherwise stay in COLLECT.
- CHANGE: `chg5`=1. Each cycle with `chg5`&&`chg_ready`, change decrements. The transfer that takes change from 1 to 0 returns the FSM to COLLECT with `chg5`=0 on the next cycle. `chg_ready` low stalls the FSM indefinitely, with no timeout.
- Any `coin`≠00 in CHANGE: `coin_reject`=1 in the same cycle and no credit is taken. `coin_reject` is 0 whenever `coin`=00.
- Maximum change after a vend is 4 steps. The change counter never underflows; in CHANGE the count is ≥1 by construction.

## Timing
- Coin sampled at edge k produces `dispense`, `chg5` and updated `credit` visible after edge k. Latency is 1 cycle; `dispense` lasts exactly 1 cycle.
- The first change token is offered in the same cycle as `dispense`. With `chg_ready` held at 1, N tokens take N cycles, and COLLECT resumes on cycle N+1 after the vend.
- A coin arriving in the last CHANGE cycle (count=1 while the handshake completes) is rejected. Coins are accepted from the next cycle onward.
- `reset_n` asserted mid-CHANGE drops `chg5` and `dispense` immediately and discards pending change and credit.
- Back-to-back coins that each complete a price each vend. `dispense` may therefore pulse on consecutive cycles if no change is owed.

## Configuration
- `VEND_CANCEL_EN` defined:
  - `cancel` port exists.
  - In COLLECT with `credit`>0: change ← `credit`, `credit` ← 0, go to CHANGE, no `dispense`.
  - Cancel has priority over a simultaneous coin, which is rejected (`coin_reject`=1).
  - Cancel with `credit`=0, or while in CHANGE, is ignored.
- `VEND_CANCEL_EN` undefined: no `cancel` port. Credit is returned only via over-payment change.

## Structure
- Package `vending_pkg`: coin code localparams (COIN_NONE/5/10/25), state enum {COLLECT, CHANGE}, and function `coin_steps(coin)` returning 0/1/2/5.
- Sub-module `vend_change_ctr`: loadable down-counter with ready/valid token output, providing `load`, `load_val`, `chg_ready`, `chg5` and `done`. The FSM and credit accumulator stay in the top level.

## Test plan (PRICE_UNITS=4)
- Coins 01,01,01,01 on consecutive cycles → `credit` 1,2,3,0; `dispense`=1 one cycle after the 4th coin; `chg5` never asserts.
- Coins 10, then 11 → sum 7; `dispense` pulse and `chg5`=1 for 3 handshakes with `chg_ready`=1; COLLECT resumes after 3 cycles.
- Vend with change 3, `chg_ready` toggled 1,0,0,1,1 → `chg5` held through the stalls; exactly 3 tokens transferred.
- Coin 01 presented during CHANGE → `coin_reject`=1 that cycle; `credit` unchanged at 0.
- `VEND_CANCEL_EN`: coins 01,10 (credit 3), then `cancel` together with coin 10 → `coin_reject`=1, no `dispense`, 3 change tokens.
- `reset_n` pulsed low mid-CHANGE (2 tokens pending) → `chg5`=0 immediately; `credit`=0; first coin after release is credited normally.
